// File: rtl/branch_resolve_pkg.sv
// ============================================================================
// Module      : branch_resolve_pkg
// Description : Shared branch-type and resolve-FSM encodings, also used by the
//               branch predictor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package branch_resolve_pkg;

    typedef enum logic [1:0] {
        BT_NONE   = 2'b00,
        BT_UNCOND = 2'b01,
        BT_REL    = 2'b10,
        BT_IND    = 2'b11
    } btype_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REDIR = 2'd1,
        ST_FLUSH = 2'd2
    } br_state_e;

    // Bit 2 marks the second slot of an 8-byte fetch pair.
    function automatic logic [31:0] fall_through(input logic [31:0] pc);
        return pc[2] ? (pc + 32'd4) : (pc + 32'd8);
    endfunction

endpackage

`default_nettype wire

// File: rtl/br_perf_cnt.sv
// ============================================================================
// Module      : br_perf_cnt
// Description : Wrapping branch-total and branch-miss performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module br_perf_cnt #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 inc_total,
    input  logic                 inc_miss,
    output logic [CNT_WIDTH-1:0] br_total,
    output logic [CNT_WIDTH-1:0] br_miss
);

    logic [CNT_WIDTH-1:0] total_d, total_q;
    logic [CNT_WIDTH-1:0] miss_d,  miss_q;

    always_comb begin
        total_d = total_q;
        miss_d  = miss_q;
        if (inc_total) total_d = total_q + CNT_WIDTH'(1);
        if (inc_miss)  miss_d  = miss_q  + CNT_WIDTH'(1);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            total_q <= '0;
            miss_q  <= '0;
        end else begin
            total_q <= total_d;
            miss_q  <= miss_d;
        end
    end

    assign br_total = total_q;
    assign br_miss  = miss_q;

endmodule

`default_nettype wire

// File: rtl/branch_resolve.sv
// ============================================================================
// Module      : branch_resolve
// Description : EX-stage branch resolution, predictor update and front-end
//               redirect handshake with younger-instruction squash.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_resolve
    import branch_resolve_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 ex_valid,
    input  logic [31:0]          ex_pc,
    input  logic [1:0]           ex_btype,
    input  logic                 ex_pred_taken,
    input  logic [31:0]          ex_pred_pc,
    input  logic                 ex_cond_true,
    input  logic [31:0]          ex_offset,
    input  logic [31:0]          ex_reg_target,
    output logic [31:0]          fact_pc,
    output logic [31:0]          fact_tpc,
    output logic                 fact_taken,
    output logic                 predict_dir_fail,
    output logic                 predict_add_fail,
    output logic                 redirect_valid,
    output logic [31:0]          redirect_pc,
    input  logic                 redirect_ack,
    output logic                 ex_kill,
    output logic [CNT_WIDTH-1:0] br_total,
    output logic [CNT_WIDTH-1:0] br_miss
);

    logic [31:0] w_fall;
    logic [31:0] w_target;
    logic        w_taken;
    logic [31:0] w_actual_next;
    logic        w_dir_fail;
    logic        w_add_fail;
    logic        w_accept;
    logic        w_mispredict;

    always_comb begin
        w_fall   = fall_through(ex_pc);
        w_target = w_fall;
        w_taken  = 1'b0;
        case (btype_e'(ex_btype))
            BT_UNCOND: begin
                w_target = ex_pc + ex_offset;
                w_taken  = 1'b1;
            end
            BT_REL: begin
                w_target = ex_pc + ex_offset;
                w_taken  = ex_cond_true;
            end
            BT_IND: begin
                w_target = ex_reg_target;
                w_taken  = 1'b1;
            end
            default: begin
                w_target = w_fall;
                w_taken  = 1'b0;
            end
        endcase
        w_actual_next = w_taken ? w_target : w_fall;
        w_dir_fail    = ex_pred_taken != w_taken;
        w_add_fail    = ex_pred_taken & w_taken & (ex_pred_pc != w_target);
    end

    // Killed instructions never reach resolution, so only IDLE can accept.
    assign w_accept     = ex_valid & ~ex_kill;
    assign w_mispredict = w_dir_fail | w_add_fail;

    // ---------------- FSM ----------------
    br_state_e state_d, state_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (w_accept && w_mispredict) state_d = ST_REDIR;
            ST_REDIR: if (redirect_ack)             state_d = ST_FLUSH;
            ST_FLUSH: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        redirect_valid = 1'b0;
        ex_kill        = 1'b0;
        case (state_q)
            ST_REDIR: begin
                redirect_valid = 1'b1;
                ex_kill        = 1'b1;
            end
            ST_FLUSH: ex_kill = 1'b1;
            default: begin
                redirect_valid = 1'b0;
                ex_kill        = 1'b0;
            end
        endcase
    end

    // ---------------- Datapath registers ----------------
    logic [31:0] redirect_pc_d, redirect_pc_q;
    logic [31:0] fact_pc_d, fact_pc_q;
    logic [31:0] fact_tpc_d, fact_tpc_q;
    logic        fact_taken_d, fact_taken_q;
    logic        dir_fail_d, dir_fail_q;
    logic        add_fail_d, add_fail_q;

    always_comb begin
        redirect_pc_d = redirect_pc_q;
        fact_pc_d     = fact_pc_q;
        fact_tpc_d    = fact_tpc_q;
        fact_taken_d  = 1'b0;
        dir_fail_d    = 1'b0;
        add_fail_d    = 1'b0;
        if (w_accept) begin
            fact_pc_d    = ex_pc;
            fact_tpc_d   = w_target;
            fact_taken_d = w_taken;
            dir_fail_d   = w_dir_fail;
            add_fail_d   = w_add_fail;
            if (w_mispredict) redirect_pc_d = w_actual_next;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            redirect_pc_q <= '0;
            fact_pc_q     <= '0;
            fact_tpc_q    <= '0;
            fact_taken_q  <= 1'b0;
            dir_fail_q    <= 1'b0;
            add_fail_q    <= 1'b0;
        end else begin
            redirect_pc_q <= redirect_pc_d;
            fact_pc_q     <= fact_pc_d;
            fact_tpc_q    <= fact_tpc_d;
            fact_taken_q  <= fact_taken_d;
            dir_fail_q    <= dir_fail_d;
            add_fail_q    <= add_fail_d;
        end
    end

    assign redirect_pc      = redirect_pc_q;
    assign fact_pc          = fact_pc_q;
    assign fact_tpc         = fact_tpc_q;
    assign fact_taken       = fact_taken_q;
    assign predict_dir_fail = dir_fail_q;
    assign predict_add_fail = add_fail_q;

    br_perf_cnt #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_perf_cnt (
        .clk       (clk),
        .rstn      (rstn),
        .inc_total (w_accept & ((ex_btype != BT_NONE) | ex_pred_taken)),
        .inc_miss  (w_accept & w_mispredict),
        .br_total  (br_total),
        .br_miss   (br_miss)
    );

endmodule

`default_nettype wire

// File: tb/tb_branch_resolve.sv
// ============================================================================
// Module      : tb_branch_resolve
// Description : Self-checking bench for branch_resolve: directed scenarios and
//               randomized traffic against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_resolve;

    localparam int CNT_WIDTH = 8;

    logic                 clk = 1'b0;
    logic                 rstn;
    logic                 ex_valid;
    logic [31:0]          ex_pc;
    logic [1:0]           ex_btype;
    logic                 ex_pred_taken;
    logic [31:0]          ex_pred_pc;
    logic                 ex_cond_true;
    logic [31:0]          ex_offset;
    logic [31:0]          ex_reg_target;
    logic [31:0]          fact_pc;
    logic [31:0]          fact_tpc;
    logic                 fact_taken;
    logic                 predict_dir_fail;
    logic                 predict_add_fail;
    logic                 redirect_valid;
    logic [31:0]          redirect_pc;
    logic                 redirect_ack;
    logic                 ex_kill;
    logic [CNT_WIDTH-1:0] br_total;
    logic [CNT_WIDTH-1:0] br_miss;

    branch_resolve #(.CNT_WIDTH(CNT_WIDTH)) dut (
        .clk              (clk),
        .rstn             (rstn),
        .ex_valid         (ex_valid),
        .ex_pc            (ex_pc),
        .ex_btype         (ex_btype),
        .ex_pred_taken    (ex_pred_taken),
        .ex_pred_pc       (ex_pred_pc),
        .ex_cond_true     (ex_cond_true),
        .ex_offset        (ex_offset),
        .ex_reg_target    (ex_reg_target),
        .fact_pc          (fact_pc),
        .fact_tpc         (fact_tpc),
        .fact_taken       (fact_taken),
        .predict_dir_fail (predict_dir_fail),
        .predict_add_fail (predict_add_fail),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .redirect_ack     (redirect_ack),
        .ex_kill          (ex_kill),
        .br_total         (br_total),
        .br_miss          (br_miss)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp_v, $time);
    endtask

    // ---------------- reference model ----------------
    bit          m_redir;        // redirect outstanding, waiting for ack
    bit          m_flush;        // one squash cycle after ack
    bit          m_last_acc;
    logic [31:0] m_rpc, m_fpc, m_ftpc;
    bit          m_ftaken, m_dir, m_add;
    int unsigned m_total, m_miss;

    function automatic logic [31:0] ref_fall(input logic [31:0] pc);
        return (pc % 8 == 4) || (pc % 8 == 5) || (pc % 8 == 6) || (pc % 8 == 7) ? pc + 4 : pc + 8;
    endfunction

    function automatic logic [31:0] ref_target(input logic [1:0] bt, input logic [31:0] pc,
                                               input logic [31:0] off, input logic [31:0] rt);
        if (bt == 2'd1 || bt == 2'd2) return pc + off;
        if (bt == 2'd3)               return rt;
        return ref_fall(pc);
    endfunction

    function automatic bit ref_taken(input logic [1:0] bt, input logic cond);
        if (bt == 2'd0) return 1'b0;
        if (bt == 2'd2) return cond;
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_redir = 0; m_flush = 0; m_last_acc = 0;
        m_rpc = 0; m_fpc = 0; m_ftpc = 0;
        m_ftaken = 0; m_dir = 0; m_add = 0;
        m_total = 0; m_miss = 0;
    endtask

    task automatic model_step();
        bit          acc, tk, dir, add;
        logic [31:0] tgt;
        acc = ex_valid && !m_redir && !m_flush;
        tgt = ref_target(ex_btype, ex_pc, ex_offset, ex_reg_target);
        tk  = ref_taken(ex_btype, ex_cond_true);
        dir = (ex_pred_taken != tk);
        add = ex_pred_taken && tk && (ex_pred_pc != tgt);
        m_last_acc = acc;
        m_ftaken = acc && tk;
        m_dir    = acc && dir;
        m_add    = acc && add;
        if (acc) begin
            m_fpc  = ex_pc;
            m_ftpc = tgt;
            if (ex_btype != 0 || ex_pred_taken) m_total++;
            if (dir || add) m_miss++;
        end
        if (m_flush) m_flush = 0;
        else if (m_redir) begin
            if (redirect_ack) begin m_redir = 0; m_flush = 1; end
        end else if (acc && (dir || add)) begin
            m_redir = 1;
            m_rpc   = tk ? tgt : ref_fall(ex_pc);
        end
    endtask

    task automatic compare_all();
        check("redirect_valid", redirect_valid, m_redir);
        check("ex_kill", ex_kill, m_redir || m_flush);
        check("redirect_pc", redirect_pc, m_rpc);
        check("fact_taken", fact_taken, m_ftaken);
        check("dir_fail", predict_dir_fail, m_dir);
        check("add_fail", predict_add_fail, m_add);
        check("br_total", br_total, m_total % (1 << CNT_WIDTH));
        check("br_miss", br_miss, m_miss % (1 << CNT_WIDTH));
        if (m_last_acc) begin
            check("fact_pc", fact_pc, m_fpc);
            check("fact_tpc", fact_tpc, m_ftpc);
        end
    endtask

    // Inputs are driven at the falling edge; one call spans one rising edge.
    task automatic step();
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [1:0] bt,
                         input logic pt, input logic [31:0] ppc, input logic cond,
                         input logic [31:0] off, input logic [31:0] rt, input logic ack);
        ex_valid = v; ex_pc = pc; ex_btype = bt; ex_pred_taken = pt; ex_pred_pc = ppc;
        ex_cond_true = cond; ex_offset = off; ex_reg_target = rt; redirect_ack = ack;
    endtask

    task automatic drive_random();
        logic [31:0] pc, off, rt, tgt;
        logic [1:0]  bt;
        logic        pt, cond;
        pc   = $urandom;
        bt   = 2'($urandom_range(0, 3));
        cond = 1'($urandom_range(0, 1));
        off  = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 255)) << 2;
        rt   = $urandom;
        tgt  = ref_target(bt, pc, off, rt);
        pt   = ($urandom_range(0, 3) == 0) ? 1'($urandom_range(0, 1)) : ref_taken(bt, cond);
        drive($urandom_range(0, 3) != 0, pc, bt, pt,
              ($urandom_range(0, 3) == 0) ? $urandom : tgt,
              cond, off, rt, $urandom_range(0, 2) == 0);
    endtask

    initial begin
        model_reset();
        rstn = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        compare_all();
        check("reset_fact_pc", fact_pc, 32'h0);
        check("reset_fact_tpc", fact_tpc, 32'h0);
        rstn = 1'b1;

        // Correct unconditional prediction: no redirect, total counts only.
        drive(1, 32'h1000, 2'b01, 1, 32'h1010, 0, 32'h10, 0, 0);
        step();
        check("d036_redir", redirect_valid, 1'b0);
        check("d036_total", br_total, 8'd1);
        check("d036_miss", br_miss, 8'd0);

        // Not-taken-predicted relative branch that is taken.
        drive(1, 32'h1000, 2'b10, 0, 32'h0, 1, 32'h40, 0, 0);
        step();
        check("d033_taken", fact_taken, 1'b1);
        check("d033_tpc", fact_tpc, 32'h1040);
        check("d033_dir", predict_dir_fail, 1'b1);
        check("d033_rpc", redirect_pc, 32'h1040);

        // Ack withheld while killed mispredicts keep arriving.
        for (int i = 0; i < 5; i++) begin
            drive(1, 32'h5000 + 32'(i * 8), 2'b01, 0, 0, 0, 32'h100, 0, 0);
            step();
            check("d037_rpc", redirect_pc, 32'h1040);
            check("d037_kill", ex_kill, 1'b1);
            check("d037_pulse", fact_taken | predict_dir_fail, 1'b0);
        end
        redirect_ack = 1;
        step();
        check("d037_flush_kill", ex_kill, 1'b1);
        check("d037_flush_rv", redirect_valid, 1'b0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        check("d037_idle_kill", ex_kill, 1'b0);

        // Predicted-taken non-branch.
        drive(1, 32'h1004, 2'b00, 1, 32'h2000, 0, 0, 0, 0);
        step();
        check("d034_dir", predict_dir_fail, 1'b1);
        check("d034_taken", fact_taken, 1'b0);
        check("d034_rpc", redirect_pc, 32'h1008);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        step();
        step();

        // Indirect target miss, with ack already high on the mispredict cycle.
        drive(1, 32'h2000, 2'b11, 1, 32'h2800, 0, 0, 32'h3000, 1);
        step();
        check("d035_add", predict_add_fail, 1'b1);
        check("d035_dir", predict_dir_fail, 1'b0);
        check("d035_rpc", redirect_pc, 32'h3000);
        check("d028_redir", redirect_valid, 1'b1);
        ex_valid = 0;
        step();
        check("d028_flush", ex_kill & ~redirect_valid, 1'b1);
        step();

        for (int i = 0; i < 3000; i++) begin
            drive_random();
            step();
        end

        // Drain, then reset in the middle of a redirect.
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) step();
        drive(1, 32'h1000, 2'b10, 0, 32'h0, 1, 32'h40, 0, 0);
        step();
        check("d038_in_redir", redirect_valid, 1'b1);
        ex_valid = 0;
        #2;
        rstn = 1'b0;
        #1;
        model_reset();
        compare_all();
        check("d038_async_rpc", redirect_pc, 32'h0);
        @(negedge clk);
        redirect_ack = 1;
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("d038_post_rv", redirect_valid, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running, expected done");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
